// File: rtl/dct_mul_sched_if.sv
// Bundles the requester, pipeline and result signals of the DCT multiply scheduler.
// The slave view belongs to the scheduler; the master view drives requests and the pipeline output.
interface dct_mul_sched_if #(
  parameter int DATA_W = 32
);
  logic              req0;
  logic [DATA_W-1:0] data0;
  logic              req1;
  logic [DATA_W-1:0] data1;
  logic              gnt0;
  logic              gnt1;
  logic              mul_en;
  logic [DATA_W-1:0] mul_din;
  logic [DATA_W-1:0] mul_dout;
  logic              res_valid0;
  logic              res_valid1;
  logic [DATA_W-1:0] res_data;
  logic              res_last;
  logic              busy;

  modport slave (
    input  req0, data0, req1, data1, mul_dout,
    output gnt0, gnt1, mul_en, mul_din,
    output res_valid0, res_valid1, res_data, res_last, busy
  );

  modport master (
    output req0, data0, req1, data1, mul_dout,
    input  gnt0, gnt1, mul_en, mul_din,
    input  res_valid0, res_valid1, res_data, res_last, busy
  );
endinterface

// File: rtl/dct_mul_sched.sv
// Shares one fixed-latency multiply pipeline between the DCT row pass (0) and column pass (1),
// granting whole BURST-beat blocks and tagging every beat so its result returns to the owner.
module dct_mul_sched #(
  parameter int DATA_W = 32,
  parameter int LAT    = 7,
  parameter int BURST  = 8
) (
  input logic           clk,
  input logic           rst,
  dct_mul_sched_if.slave bus
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rr_q, rr_d;
  logic [LAT-1:0]     trk_vld_q;
  logic [LAT-1:0]     trk_tag_q;
  logic [LAT-1:0]     trk_last_q;

  logic own0, own1, beat, last_beat, other_req, same_req;

  always_comb begin
    own0      = (state_q == OWN0);
    own1      = (state_q == OWN1);
    beat      = (own0 & bus.req0) | (own1 & bus.req1);
    last_beat = beat && (cnt_q == CNT_W'(BURST - 1));
    other_req = own0 ? bus.req1 : bus.req0;
    same_req  = own0 ? bus.req0 : bus.req1;
  end

  // Next state: rr_q == 0 favours requester 0 when both ask at once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = rr_q ? OWN1 : OWN0;
        else if (bus.req0)        state_d = OWN0;
        else if (bus.req1)        state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (beat) begin
          if (last_beat) begin
            cnt_d = '0;
            rr_d  = own0;
            if (other_req)     state_d = own0 ? OWN1 : OWN0;
            else if (same_req) state_d = state_q;
            else               state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tracking line advances every cycle so stage LAT-1 lines up with mul_dout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      trk_vld_q  <= '0;
      trk_tag_q  <= '0;
      trk_last_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      trk_vld_q  <= {trk_vld_q[LAT-2:0], beat};
      trk_tag_q  <= {trk_tag_q[LAT-2:0], own1};
      trk_last_q <= {trk_last_q[LAT-2:0], last_beat};
    end
  end

  always_comb begin
    bus.gnt0       = own0;
    bus.gnt1       = own1;
    bus.mul_en     = beat;
    bus.mul_din    = '0;
    if (beat) bus.mul_din = own1 ? bus.data1 : bus.data0;
    bus.res_data   = bus.mul_dout;
    bus.res_valid0 = trk_vld_q[LAT-1] & ~trk_tag_q[LAT-1];
    bus.res_valid1 = trk_vld_q[LAT-1] &  trk_tag_q[LAT-1];
    bus.res_last   = trk_vld_q[LAT-1] &  trk_last_q[LAT-1];
    bus.busy       = (state_q != IDLE) | (|trk_vld_q);
  end

endmodule
